// File: rtl/fp_mult_result_sink_if.sv
// Stream bundle between the multiplier result port, the result sink and its consumer.
// The sink takes the slave view; the environment driving results and ready takes the master view.
interface fp_mult_result_sink_if;
  logic        s_axis_result_tvalid;
  logic        s_axis_result_tready;
  logic [31:0] s_axis_result_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tuser;

  modport slave (
    input  s_axis_result_tvalid,
    input  s_axis_result_tdata,
    input  m_axis_tready,
    output s_axis_result_tready,
    output m_axis_tvalid,
    output m_axis_tdata,
    output m_axis_tuser
  );

  modport master (
    output s_axis_result_tvalid,
    output s_axis_result_tdata,
    output m_axis_tready,
    input  s_axis_result_tready,
    input  m_axis_tvalid,
    input  m_axis_tdata,
    input  m_axis_tuser
  );
endinterface

// File: rtl/fp_mult_result_sink.sv
// Result sink for the FP multiplier: classifies each single-precision result, buffers
// {class, data} in a fall-through FIFO and keeps saturating per-class statistics.
module fp_mult_result_sink #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  fp_mult_result_sink_if.slave    bus,
  input  logic                    i_clr_stats,
  output logic [CNT_W-1:0]        o_cnt_nan,
  output logic [CNT_W-1:0]        o_cnt_inf,
  output logic [CNT_W-1:0]        o_cnt_zero,
  output logic [CNT_W-1:0]        o_cnt_sub,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    FULL_LEVEL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [7:0]  in_exp;
  logic [22:0] in_man;
  logic        exp_ones;
  logic        exp_zero;
  logic        man_zero;
  logic [3:0]  in_flags;

  logic [35:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q, ready_d;
  logic          push;
  logic          pop;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

  // Flag order {nan, inf, zero, sub}; the sign bit plays no part in the class.
  always_comb begin
    in_exp   = bus.s_axis_result_tdata[30:23];
    in_man   = bus.s_axis_result_tdata[22:0];
    exp_ones = (in_exp == 8'hFF);
    exp_zero = (in_exp == 8'h00);
    man_zero = (in_man == 23'd0);
    in_flags = {exp_ones & ~man_zero, exp_ones & man_zero,
                exp_zero & man_zero,  exp_zero & ~man_zero};
  end

  // Ready is computed from the next occupancy so the registered copy tracks the level.
  always_comb begin
    push     = bus.s_axis_result_tvalid & ready_q;
    pop      = (level_q != '0) & bus.m_axis_tready;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    ready_d  = (level_d != FULL_LEVEL);
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (i_clr_stats) begin
        cnt_d[i] = '0;
      end else if (push && in_flags[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because valid follows the level.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_flags, bus.s_axis_result_tdata};
    end
  end

  assign bus.s_axis_result_tready = ready_q;
  assign bus.m_axis_tvalid        = (level_q != '0);
  assign bus.m_axis_tuser         = mem_q[rd_ptr_q][35:32];
  assign bus.m_axis_tdata         = mem_q[rd_ptr_q][31:0];

  assign o_cnt_nan  = cnt_q[3];
  assign o_cnt_inf  = cnt_q[2];
  assign o_cnt_zero = cnt_q[1];
  assign o_cnt_sub  = cnt_q[0];
  assign o_level    = level_q;

endmodule

// File: tb/tb_fp_mult_result_sink.sv
// Scoreboard bench for fp_mult_result_sink: random and directed result streams are checked
// against a queue-based reference of the FIFO contents, class flags and saturating counters.
module tb_fp_mult_result_sink;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic clr_stats = 1'b0;
  logic [CNT_W-1:0] cnt_nan, cnt_inf, cnt_zero, cnt_sub;
  logic [$clog2(DEPTH):0] level;

  fp_mult_result_sink_if bus();

  fp_mult_result_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .i_clr_stats (clr_stats),
    .o_cnt_nan   (cnt_nan),
    .o_cnt_inf   (cnt_inf),
    .o_cnt_zero  (cnt_zero),
    .o_cnt_sub   (cnt_sub),
    .o_level     (level)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [35:0] exp_q[$];
  int cnt_model[4];
  int lvl_model = 0;
  int edges_since_rst = 0;
  bit rand_done = 1'b0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
    n_total++;
    if (actual === required) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
  endtask

  // Class from the IEEE-754 fields: exponent all-ones is inf/NaN, all-zeros is zero/subnormal.
  function automatic logic [3:0] ref_class(input logic [31:0] d);
    int e;
    int m;
    e = int'((d >> 23) % 256);
    m = int'(d % 32'h0080_0000);
    if (e == 255) return (m != 0) ? 4'b1000 : 4'b0100;
    if (e == 0)   return (m != 0) ? 4'b0001 : 4'b0010;
    return 4'b0000;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 4))
      0:       e = 8'hFF;
      1:       e = 8'h00;
      default: e = 8'($urandom_range(0, 255));
    endcase
    m = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges_since_rst <= 0;
    else        edges_since_rst <= edges_since_rst + 1;
  end

  // Reference model: decides from the bench's own occupancy what the next edge does.
  initial begin : stat_monitor
    bit ready_exp;
    bit acc;
    bit pop;
    logic [3:0] cls;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lvl_model = 0;
        cnt_model = '{default: 0};
        exp_q.delete();
      end else begin
        ready_exp = (edges_since_rst > 0) && (lvl_model < DEPTH);
        check_output("s_tready", bus.s_axis_result_tready, ready_exp);
        check_output("m_tvalid", bus.m_axis_tvalid, lvl_model > 0);
        check_output("o_level", level, lvl_model);
        check_output("cnt_nan", cnt_nan, cnt_model[3]);
        check_output("cnt_inf", cnt_inf, cnt_model[2]);
        check_output("cnt_zero", cnt_zero, cnt_model[1]);
        check_output("cnt_sub", cnt_sub, cnt_model[0]);
        acc = bus.s_axis_result_tvalid && ready_exp;
        pop = (lvl_model > 0) && bus.m_axis_tready;
        cls = ref_class(bus.s_axis_result_tdata);
        if (clr_stats) begin
          cnt_model = '{default: 0};
        end else if (acc) begin
          for (int i = 0; i < 4; i++)
            if (cls[i] && cnt_model[i] < CNT_MAX) cnt_model[i]++;
        end
        if (acc) exp_q.push_back({cls, bus.s_axis_result_tdata});
        lvl_model = lvl_model + int'(acc) - int'(pop);
      end
    end
  end

  initial begin : out_monitor
    logic [35:0] exp_beat;
    forever begin
      @(negedge clk);
      if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
        check_output("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_beat = exp_q.pop_front();
          check_output("m_tdata", bus.m_axis_tdata, exp_beat[31:0]);
          check_output("m_tuser", bus.m_axis_tuser, exp_beat[35:32]);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] d);
    int budget;
    budget = 0;
    bus.s_axis_result_tvalid = 1'b1;
    bus.s_axis_result_tdata  = d;
    @(negedge clk);
    while (!bus.s_axis_result_tready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) check_output("accept_timeout", bus.s_axis_result_tready, 1);
    @(posedge clk);
    #1;
    bus.s_axis_result_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (level != 0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("drain_level", level, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [31:0] class_vec [5];
    class_vec = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000001, 32'h3F800000};
    bus.s_axis_result_tvalid = 1'b0;
    bus.s_axis_result_tdata  = '0;
    bus.m_axis_tready        = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_tvalid", bus.m_axis_tvalid, 0);
    check_output("rst_tready", bus.s_axis_result_tready, 0);
    check_output("rst_level", level, 0);
    check_output("rst_cnt_nan", cnt_nan, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check_output("ready_after_release", bus.s_axis_result_tready, 1);

    $display("[TB] classification");
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus(class_vec[i]);
    repeat (4) @(posedge clk);
    #1;
    check_output("class_cnt_nan", cnt_nan, 1);
    check_output("class_cnt_inf", cnt_inf, 1);
    check_output("class_cnt_zero", cnt_zero, 1);
    check_output("class_cnt_sub", cnt_sub, 1);

    $display("[TB] fill");
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) apply_stimulus(32'h3F800000 + i);
    check_output("fill_level", level, 16);
    check_output("fill_ready_low", bus.s_axis_result_tready, 0);
    fork
      for (int i = 16; i < 20; i++) apply_stimulus(32'h3F800000 + i);
      begin
        repeat (4) @(posedge clk);
        #1 bus.m_axis_tready = 1'b1;
      end
    join
    wait_drain(100);

    $display("[TB] simultaneous push/pop");
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus(rand_fp());
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(rand_fp());
      check_output("pushpop_level", level, 5);
    end
    wait_drain(100);

    $display("[TB] saturation and clear");
    clr_stats = 1'b1;
    @(posedge clk);
    #1 clr_stats = 1'b0;
    check_output("clr_cnt_nan", cnt_nan, 0);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(32'h7F800001);
      check_output("nan_sat", cnt_nan, (i + 1 > CNT_MAX) ? CNT_MAX : i + 1);
    end
    clr_stats = 1'b1;
    apply_stimulus(32'h7F800001);
    clr_stats = 1'b0;
    check_output("clr_priority", cnt_nan, 0);
    wait_drain(100);

    $display("[TB] random traffic");
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          clr_stats = ($urandom_range(0, 19) == 0);
          apply_stimulus(rand_fp());
          clr_stats = 1'b0;
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 bus.m_axis_tready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    bus.m_axis_tready = 1'b1;
    wait_drain(100);

    $display("[TB] reset mid-operation");
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) apply_stimulus((i < 3) ? 32'hFF800000 : 32'hC0000000 + i);
    check_output("pre_rst_level", level, 7);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_tvalid", bus.m_axis_tvalid, 0);
    check_output("midrst_level", level, 0);
    check_output("midrst_ready", bus.s_axis_result_tready, 0);
    check_output("midrst_cnt_nan", cnt_nan, 0);
    check_output("midrst_cnt_inf", cnt_inf, 0);
    check_output("midrst_cnt_zero", cnt_zero, 0);
    check_output("midrst_cnt_sub", cnt_sub, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check_output("release_ready_low", bus.s_axis_result_tready, 0);
    @(posedge clk);
    #1 check_output("release_ready_high", bus.s_axis_result_tready, 1);
    apply_stimulus(32'h12345678);
    check_output("post_rst_tvalid", bus.m_axis_tvalid, 1);
    check_output("post_rst_first", bus.m_axis_tdata, 32'h12345678);
    bus.m_axis_tready = 1'b1;
    wait_drain(100);
    repeat (2) @(posedge clk);
    #1 check_output("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
